store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : MIPS-style store buffer: byte-lane encoding of SB/SH/SW/SWL/SWR
//               into a circular FIFO drained to memory, with a load-hit check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 32,
    parameter int UNALIGNED_EN = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       st_valid,
    input  logic [2:0]                 st_op,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    output logic                       st_ready,
    output logic                       ades,
    output logic                       mem_en,
    output logic [3:0]                 mem_wen,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [2:0] c_OP_SB  = 3'b000;
    localparam logic [2:0] c_OP_SH  = 3'b001;
    localparam logic [2:0] c_OP_SW  = 3'b010;
    localparam logic [2:0] c_OP_SWL = 3'b011;
    localparam logic [2:0] c_OP_SWR = 3'b100;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DEPTH-1:0]   r_valid;
    logic [ADDR_W-3:0]  r_addr [DEPTH];
    logic [3:0]         r_wen  [DEPTH];
    logic [31:0]        r_data [DEPTH];

    logic        w_legal;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_wen;
    logic [31:0] w_data;
    logic        w_hit;
    logic        w_unused_ld_lo;

    assign w_unused_ld_lo = &{1'b0, ld_addr[1:0]};

    assign ades = st_valid &&
                  (((st_op == c_OP_SH) && st_addr[0]) ||
                   ((st_op == c_OP_SW) && (st_addr[1:0] != 2'b00)));

    assign w_legal = (st_op == c_OP_SB) || (st_op == c_OP_SH) || (st_op == c_OP_SW) ||
                     ((UNALIGNED_EN != 0) && ((st_op == c_OP_SWL) || (st_op == c_OP_SWR)));

    assign st_ready = (r_count != c_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign mem_en   = !empty;
    assign w_push   = st_valid && st_ready && !ades && w_legal;
    assign w_pop    = mem_en && mem_ack;

    // Head fields are gated so idle and reset outputs read as zero.
    assign mem_wen   = mem_en ? r_wen[r_rd_ptr] : 4'b0000;
    assign mem_addr  = mem_en ? {r_addr[r_rd_ptr], 2'b00} : '0;
    assign mem_wdata = mem_en ? r_data[r_rd_ptr] : 32'h0;

    always_comb begin
        w_wen  = 4'b0000;
        w_data = st_data;
        case (st_op)
            c_OP_SB: begin
                w_wen  = 4'b0001 << st_addr[1:0];
                w_data = {4{st_data[7:0]}};
            end
            c_OP_SH: begin
                w_wen  = st_addr[1] ? 4'b1100 : 4'b0011;
                w_data = {2{st_data[15:0]}};
            end
            c_OP_SW: w_wen = 4'b1111;
            c_OP_SWL: begin
                case (st_addr[1:0])
                    2'b00:   begin w_wen = 4'b0001; w_data = st_data >> 24; end
                    2'b01:   begin w_wen = 4'b0011; w_data = st_data >> 16; end
                    2'b10:   begin w_wen = 4'b0111; w_data = st_data >> 8;  end
                    default: begin w_wen = 4'b1111; w_data = st_data;       end
                endcase
            end
            c_OP_SWR: begin
                case (st_addr[1:0])
                    2'b00:   begin w_wen = 4'b1111; w_data = st_data;       end
                    2'b01:   begin w_wen = 4'b1110; w_data = st_data << 8;  end
                    2'b10:   begin w_wen = 4'b1100; w_data = st_data << 16; end
                    default: begin w_wen = 4'b1000; w_data = st_data << 24; end
                endcase
            end
            default: ;
        endcase
    end

    // The popping head still counts as pending for the load check.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == ld_addr[ADDR_W-1:2])) begin
                w_hit = 1'b1;
            end
        end
    end
    assign ld_hit = w_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + c_PTR_W'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr[ADDR_W-1:2];
            r_wen[r_wr_ptr]  <= w_wen;
            r_data[r_wr_ptr] <= w_data;
        end
    end

endmodule

`default_nettype wire
